// File: rtl/entry_pkg.sv
// Shared definitions for the keypad digit-entry front end of the equation solvers.
package entry_pkg;

  localparam logic [3:0]  KEY_MAX_DIGIT = 4'h9;
  localparam logic [3:0]  KEY_ENTER     = 4'hA;
  localparam logic [3:0]  KEY_BKSP      = 4'hB;
  localparam logic [3:0]  KEY_CLEAR     = 4'hC;

  // Largest value that may be submitted; compared at 12 bits against 10*value+k.
  localparam logic [11:0] MAX_VALUE     = 12'd255;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ENTRY   = 2'd1,
    GO_HIGH = 2'd2,
    GAP     = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_HIGH = 2'd1,
    PH_GAP  = 2'd2
  } phase_t;

  // Binary value of three BCD digits; at most 999, so 10 bits suffice.
  function automatic logic [9:0] digits_value(input logic [3:0] hundreds,
                                              input logic [3:0] tens,
                                              input logic [3:0] ones);
    return ({6'd0, hundreds} * 10'd100) + ({6'd0, tens} * 10'd10) + {6'd0, ones};
  endfunction

endpackage

// File: rtl/go_strobe_timer.sv
// Go handshake timer: a start pulse yields GO_CYCLES cycles of go high, then
// GAP_CYCLES cycles of go low, with a done pulse in the last gap cycle.
// abort returns the timer to idle on the next edge.
module go_strobe_timer #(
  parameter int GO_CYCLES  = 4,
  parameter int GAP_CYCLES = 4
) (
  input  logic Clock,
  input  logic Reset,
  input  logic start,
  input  logic abort,
  output logic go,
  output logic high_done,
  output logic done
);
  import entry_pkg::*;

  localparam logic [15:0] GO_LAST  = 16'(GO_CYCLES - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

  phase_t      phase_r, phase_s;
  logic [15:0] cnt_r, cnt_s;

  // Phase and cycle counter registers.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      phase_r <= PH_IDLE;
      cnt_r   <= 16'd0;
    end else begin
      phase_r <= phase_s;
      cnt_r   <= cnt_s;
    end
  end

  // Advance through high and gap phases, counting cycles in each.
  always_comb begin
    phase_s = phase_r;
    cnt_s   = cnt_r;
    if (abort) begin
      phase_s = PH_IDLE;
      cnt_s   = 16'd0;
    end else begin
      case (phase_r)
        PH_IDLE: begin
          if (start) begin
            phase_s = PH_HIGH;
            cnt_s   = 16'd0;
          end else begin
            phase_s = PH_IDLE;
            cnt_s   = 16'd0;
          end
        end
        PH_HIGH: begin
          if (cnt_r == GO_LAST) begin
            phase_s = PH_GAP;
            cnt_s   = 16'd0;
          end else begin
            cnt_s   = cnt_r + 16'd1;
          end
        end
        PH_GAP: begin
          if (cnt_r == GAP_LAST) begin
            phase_s = PH_IDLE;
            cnt_s   = 16'd0;
          end else begin
            cnt_s   = cnt_r + 16'd1;
          end
        end
        default: begin
          phase_s = PH_IDLE;
          cnt_s   = 16'd0;
        end
      endcase
    end
  end

  assign go        = (phase_r == PH_HIGH);
  assign high_done = (phase_r == PH_HIGH) && (cnt_r == GO_LAST);
  assign done      = (phase_r == PH_GAP) && (cnt_r == GAP_LAST);

endmodule

// File: rtl/digit_entry.sv
// Keypad digit entry: collects up to MAX_DIGITS decimal digits, submits the
// value on Enter as DataIn with one Go high-then-low handshake.
module digit_entry #(
  parameter int GO_CYCLES  = 4,
  parameter int GAP_CYCLES = 4,
  parameter int MAX_DIGITS = 3
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        enable,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic [7:0]  DataIn,
  output logic        Go,
  output logic [7:0]  entry_value,
  output logic [11:0] bcd_digits,
  output logic [1:0]  digit_count,
  output logic        reject,
  output logic        busy
);
  import entry_pkg::*;

  localparam logic [1:0] MAX_COUNT = 2'(MAX_DIGITS);

  state_t      state_r, state_s;
  logic [3:0]  d2_r, d1_r, d0_r;
  logic [3:0]  d2_s, d1_s, d0_s;
  logic [1:0]  count_r, count_s;
  logic [7:0]  value_r;
  logic [7:0]  data_r;
  logic        reject_r, reject_s;
  logic        start_s;
  logic        busy_s;
  logic [11:0] scaled_s;
  logic        digit_ok_s;
  logic        go_s, high_done_s, gap_done_s;

  go_strobe_timer #(
    .GO_CYCLES (GO_CYCLES),
    .GAP_CYCLES(GAP_CYCLES)
  ) u_timer (
    .Clock    (Clock),
    .Reset    (Reset),
    .start    (start_s),
    .abort    (!enable),
    .go       (go_s),
    .high_done(high_done_s),
    .done     (gap_done_s)
  );

  // State register.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state: enable low always forces IDLE; the timer paces GO_HIGH and GAP.
  always_comb begin
    state_s = state_r;
    if (!enable) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    state_s = ENTRY;
        ENTRY:   state_s = start_s ? GO_HIGH : ENTRY;
        GO_HIGH: state_s = high_done_s ? GAP : GO_HIGH;
        GAP:     state_s = gap_done_s ? ENTRY : GAP;
        default: state_s = IDLE;
      endcase
    end
  end

  // State-decoded outputs.
  always_comb begin
    busy_s = 1'b0;
    case (state_r)
      GO_HIGH: busy_s = 1'b1;
      GAP:     busy_s = 1'b1;
      default: busy_s = 1'b0;
    endcase
  end

  // Key handling: digit accept rule, backspace, clear, Enter and refusals.
  always_comb begin
    d2_s       = d2_r;
    d1_s       = d1_r;
    d0_s       = d0_r;
    count_s    = count_r;
    reject_s   = 1'b0;
    start_s    = 1'b0;
    scaled_s   = ({4'd0, value_r} * 12'd10) + {8'd0, key_code};
    digit_ok_s = (count_r < MAX_COUNT) && (scaled_s <= MAX_VALUE);
    if (!enable) begin
      // Dropping enable wins over any key on the same edge.
      d2_s    = 4'd0;
      d1_s    = 4'd0;
      d0_s    = 4'd0;
      count_s = 2'd0;
    end else if (key_valid && (state_r == ENTRY)) begin
      if (key_code <= KEY_MAX_DIGIT) begin
        if (digit_ok_s) begin
          d2_s    = d1_r;
          d1_s    = d0_r;
          d0_s    = key_code;
          count_s = count_r + 2'd1;
        end else begin
          reject_s = 1'b1;
        end
      end else begin
        case (key_code)
          KEY_ENTER: begin
            if (count_r != 2'd0) begin
              start_s = 1'b1;
              d2_s    = 4'd0;
              d1_s    = 4'd0;
              d0_s    = 4'd0;
              count_s = 2'd0;
            end else begin
              reject_s = 1'b1;
            end
          end
          KEY_BKSP: begin
            if (count_r != 2'd0) begin
              d0_s    = d1_r;
              d1_s    = d2_r;
              d2_s    = 4'd0;
              count_s = count_r - 2'd1;
            end else begin
              reject_s = 1'b1;
            end
          end
          KEY_CLEAR: begin
            d2_s    = 4'd0;
            d1_s    = 4'd0;
            d0_s    = 4'd0;
            count_s = 2'd0;
          end
          default: reject_s = 1'b1;
        endcase
      end
    end else if (key_valid && ((state_r == GO_HIGH) || (state_r == GAP))) begin
      reject_s = 1'b1;
    end else begin
      reject_s = 1'b0;
    end
  end

  // Digit, count, live value, reject pulse and submitted value registers.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      d2_r     <= 4'd0;
      d1_r     <= 4'd0;
      d0_r     <= 4'd0;
      count_r  <= 2'd0;
      value_r  <= 8'd0;
      reject_r <= 1'b0;
      data_r   <= 8'd0;
    end else begin
      d2_r     <= d2_s;
      d1_r     <= d1_s;
      d0_r     <= d0_s;
      count_r  <= count_s;
      value_r  <= 8'(digits_value(d2_s, d1_s, d0_s));
      reject_r <= reject_s;
      data_r   <= start_s ? value_r : data_r;
    end
  end

  assign DataIn      = data_r;
  assign Go          = go_s;
  assign entry_value = value_r;
  assign bcd_digits  = {d2_r, d1_r, d0_r};
  assign digit_count = count_r;
  assign reject      = reject_r;
  assign busy        = busy_s;

endmodule

// File: tb/tb_digit_entry.sv
// Bench for digit_entry: directed scenarios then random keystrokes, every
// cycle compared against a queue-based model of the entry rules.
module tb_digit_entry;

  localparam int GO_C   = 4;
  localparam int GAP_C  = 4;
  localparam int MAXD   = 3;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        enable;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [7:0]  DataIn;
  logic        Go;
  logic [7:0]  entry_value;
  logic [11:0] bcd_digits;
  logic [1:0]  digit_count;
  logic        reject;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // model state: mode 0 idle, 1 entry, 2 busy (t = cycle within handshake)
  int m_q[$];
  int m_data = 0;
  int m_mode = 0;
  int m_t    = 0;
  bit m_rej  = 1'b0;

  // values seen by a solver on each Go rising edge
  int captured[$];
  logic go_prev = 1'b0;

  digit_entry #(.GO_CYCLES(GO_C), .GAP_CYCLES(GAP_C), .MAX_DIGITS(MAXD)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .enable     (enable),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .DataIn     (DataIn),
    .Go         (Go),
    .entry_value(entry_value),
    .bcd_digits (bcd_digits),
    .digit_count(digit_count),
    .reject     (reject),
    .busy       (busy)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) begin
    go_prev <= Go;
    if (Go && !go_prev) captured.push_back(int'(DataIn));
  end

  function automatic int m_value();
    int v = 0;
    foreach (m_q[i]) v = v * 10 + m_q[i];
    return v;
  endfunction

  function automatic logic [11:0] m_bcd();
    logic [3:0] d0 = 4'd0, d1 = 4'd0, d2 = 4'd0;
    int n = m_q.size();
    if (n >= 1) d0 = 4'(m_q[n-1]);
    if (n >= 2) d1 = 4'(m_q[n-2]);
    if (n >= 3) d2 = 4'(m_q[n-3]);
    return {d2, d1, d0};
  endfunction

  task automatic model_step(input bit rst, input bit en, input bit kv, input logic [3:0] kc);
    int nv;
    m_rej = 1'b0;
    if (rst) begin
      m_q.delete(); m_data = 0; m_mode = 0; m_t = 0;
    end else if (!en) begin
      m_q.delete(); m_mode = 0; m_t = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (kv) begin
        if (kc <= 4'd9) begin
          nv = m_value() * 10 + int'(kc);
          if (m_q.size() < MAXD && nv <= 255) m_q.push_back(int'(kc));
          else m_rej = 1'b1;
        end else if (kc == 4'hA) begin
          if (m_q.size() > 0) begin
            m_data = m_value(); m_q.delete(); m_mode = 2; m_t = 1;
          end else m_rej = 1'b1;
        end else if (kc == 4'hB) begin
          if (m_q.size() > 0) void'(m_q.pop_back());
          else m_rej = 1'b1;
        end else if (kc == 4'hC) begin
          m_q.delete();
        end else begin
          m_rej = 1'b1;
        end
      end
    end else begin
      if (kv) m_rej = 1'b1;
      m_t++;
      if (m_t > GO_C + GAP_C) begin m_mode = 1; m_t = 0; end
    end
  endtask

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("entry_value", 12'(entry_value), 12'(m_value()));
    check("bcd_digits",  bcd_digits, m_bcd());
    check("digit_count", 12'(digit_count), 12'(m_q.size()));
    check("reject",      12'(reject), 12'(m_rej));
    check("Go",          12'(Go), 12'(m_mode == 2 && m_t <= GO_C));
    check("busy",        12'(busy), 12'(m_mode == 2));
    check("DataIn",      12'(DataIn), 12'(m_data));
  endtask

  task automatic step(input bit rst, input bit en, input bit kv, input logic [3:0] kc);
    Reset = rst; enable = en; key_valid = kv; key_code = kc;
    @(posedge Clock);
    model_step(rst, en, kv, kc);
    #1;
    check_all();
  endtask

  task automatic key(input logic [3:0] kc);
    step(1'b0, 1'b1, 1'b1, kc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 4'd0);
  endtask

  initial begin
    int busy_n, go_n, r;
    logic [3:0] kc;
    Reset = 1'b1; enable = 1'b0; key_valid = 1'b0; key_code = 4'd0;

    // reset state
    step(1'b1, 1'b0, 1'b0, 4'd0);
    step(1'b1, 1'b0, 1'b0, 4'd0);
    check("reset_DataIn", 12'(DataIn), 12'd0);
    step(1'b0, 1'b1, 1'b0, 4'd0);

    // 1,2,3,Enter and the handshake shape
    key(4'd1); check("ev_1", 12'(entry_value), 12'd1);
    key(4'd2); check("ev_12", 12'(entry_value), 12'd12);
    key(4'd3); check("ev_123", 12'(entry_value), 12'd123);
    key(4'hA);
    check("go_after_enter", 12'(Go), 12'd1);
    check("datain_123", 12'(DataIn), 12'd123);
    busy_n = int'(busy); go_n = int'(Go);
    for (int i = 0; i < 8; i++) begin
      idle(1);
      busy_n += int'(busy); go_n += int'(Go);
    end
    check("busy_cycles", 12'(busy_n), 12'd8);
    check("go_cycles", 12'(go_n), 12'd4);
    check("ev_after_submit", 12'(entry_value), 12'd0);

    // 256 overflow, 255 boundary, fourth digit
    key(4'd2); key(4'd5); key(4'd6);
    check("rej_256", 12'(reject), 12'd1);
    check("ev_25", 12'(entry_value), 12'd25);
    check("cnt_2", 12'(digit_count), 12'd2);
    key(4'hC);
    key(4'd2); key(4'd5); key(4'd5);
    check("ev_255", 12'(entry_value), 12'd255);
    key(4'd1);
    check("rej_4th", 12'(reject), 12'd1);
    key(4'hC);

    // 4,7,Bksp,9,Enter -> 49; Clear after 8
    key(4'd4); key(4'd7); key(4'hB); key(4'd9); key(4'hA);
    check("datain_49", 12'(DataIn), 12'd49);
    idle(8);
    key(4'd8); key(4'hC);
    check("clear_ev", 12'(entry_value), 12'd0);
    check("clear_norej", 12'(reject), 12'd0);

    // empty Enter; key during GO_HIGH
    key(4'hA);
    check("rej_empty_enter", 12'(reject), 12'd1);
    check("go_empty_enter", 12'(Go), 12'd0);
    key(4'd0); key(4'hB); key(4'hE);
    key(4'd7); key(4'hA);
    key(4'd9);
    check("rej_busy", 12'(reject), 12'd1);
    check("datain_7", 12'(DataIn), 12'd7);
    idle(8);
    key(4'd1); key(4'd2); key(4'hA);
    idle(8);
    check("solver_count", 12'(captured.size()), 12'd4);
    if (captured.size() >= 2) begin
      check("solver_x", 12'(captured[captured.size()-2]), 12'd7);
      check("solver_y", 12'(captured[captured.size()-1]), 12'd12);
    end

    // enable drop in 2nd GO_HIGH cycle with a key on the same edge
    key(4'd3); key(4'hA);
    step(1'b0, 1'b0, 1'b1, 4'd5);
    check("abort_go", 12'(Go), 12'd0);
    check("abort_busy", 12'(busy), 12'd0);
    check("abort_norej", 12'(reject), 12'd0);
    check("abort_datain", 12'(DataIn), 12'd3);
    step(1'b0, 1'b1, 1'b1, 4'd5);
    check("idle_key_ignored", 12'(digit_count), 12'd0);

    // reset mid-entry
    key(4'd4); key(4'd5);
    step(1'b1, 1'b1, 1'b1, 4'd6);
    check("rst_ev", 12'(entry_value), 12'd0);
    check("rst_datain", 12'(DataIn), 12'd0);
    step(1'b0, 1'b1, 1'b0, 4'd0);

    // random keystrokes against the model
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 19);
      if (r < 10)      kc = 4'(r);
      else if (r < 14) kc = 4'hA;
      else if (r < 16) kc = 4'hB;
      else if (r < 17) kc = 4'hC;
      else             kc = 4'(r - 4);
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 39) != 0),
           ($urandom_range(0, 1) == 1), kc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
